// File: rtl/pm_arbiter_pkg.sv
// Shared types and constants for the program-memory arbiter.
package pm_arbiter_pkg;

    localparam int unsigned PM_DEPTH  = 16;
    localparam int unsigned WORD_W    = 8;
    localparam int unsigned ADDR_W    = 4;

    // Bit positions inside the one-hot grant vector of pm_rr_arb.
    localparam int unsigned GNT_FETCH = 0;
    localparam int unsigned GNT_STORE = 1;

    typedef enum logic [1:0] {
        StLoad  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } pm_state_e;

    // Saturating 8-bit increment used by the collision counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pm_rr_arb.sv
// Two-requester fetch/store arbiter: store normally wins a collision, but a
// fetch that lost the previous cycle wins the next one.
module pm_rr_arb
    import pm_arbiter_pkg::*;
(
    input  logic       i_en,
    input  logic       i_fetch_req,
    input  logic       i_store_req,
    input  logic       i_last_loser,
    output logic [1:0] o_gnt
);

    // One-hot grant decision, all-zero when disabled.
    always_comb begin
        o_gnt = 2'b00;
        if (i_en) begin
            if (i_fetch_req && i_store_req) begin
                if (i_last_loser) begin
                    o_gnt[GNT_FETCH] = 1'b1;
                end else begin
                    o_gnt[GNT_STORE] = 1'b1;
                end
            end else if (i_fetch_req) begin
                o_gnt[GNT_FETCH] = 1'b1;
            end else if (i_store_req) begin
                o_gnt[GNT_STORE] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pm_arbiter.sv
// Program-memory owner: loads the program from the loader port while the CPU
// is held, then arbitrates CPU fetches and stores against the same memory.
module pm_arbiter
    import pm_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = PM_DEPTH
) (
    input  logic                     clk_arb,
    input  logic                     rst_arb,
    input  logic                     ld_req,
    input  logic [WORD_W-1:0]        ld_data,
    output logic                     ld_gnt,
    input  logic                     fetch_req,
    input  logic [$clog2(DEPTH)-1:0] fetch_addr,
    output logic                     fetch_gnt,
    output logic                     fetch_valid,
    output logic [WORD_W-1:0]        fetch_data,
    input  logic                     st_req,
    input  logic [$clog2(DEPTH)-1:0] st_addr,
    input  logic [WORD_W-1:0]        st_data,
    output logic                     st_gnt,
    input  logic                     reload,
    output logic                     cpu_hold,
    output logic                     load_done,
    output logic [7:0]               conflict_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);

    pm_state_e         r_state;
    logic [AW-1:0]     r_ld_ptr;
    logic              r_last_loser;
    logic [7:0]        r_conflict_cnt;
    logic              r_fetch_valid;
    logic [WORD_W-1:0] r_fetch_data;
    logic              r_cpu_hold;
    logic [WORD_W-1:0] r_mem [DEPTH];

    logic              w_in_load;
    logic              w_in_run;
    logic              w_ld_gnt;
    logic              w_ld_last;
    logic              w_both;
    logic [1:0]        w_gnt;
    logic              w_fetch_gnt;
    logic              w_st_gnt;

    // Reset has priority: no grant is issued in a reset cycle.
    assign w_in_load   = (r_state == StLoad) && !rst_arb;
    assign w_in_run    = (r_state == StRun) && !rst_arb;
    assign w_ld_gnt    = w_in_load && ld_req;
    assign w_ld_last   = w_ld_gnt && (r_ld_ptr == AW'(DEPTH - 1));
    assign w_both      = fetch_req && st_req;
    assign w_fetch_gnt = w_gnt[GNT_FETCH];
    assign w_st_gnt    = w_gnt[GNT_STORE];

    pm_rr_arb u_rr_arb (
        .i_en         (w_in_run),
        .i_fetch_req  (fetch_req),
        .i_store_req  (st_req),
        .i_last_loser (r_last_loser),
        .o_gnt        (w_gnt)
    );

    // Memory write port; load and store grants are exclusive by state.
    always_ff @(posedge clk_arb) begin
        if (w_ld_gnt) begin
            r_mem[r_ld_ptr] <= ld_data;
        end else if (w_st_gnt) begin
            r_mem[st_addr] <= st_data;
        end
    end

    // State machine, load pointer, arbitration history, read port and counter.
    always_ff @(posedge clk_arb) begin
        if (rst_arb) begin
            r_state        <= StLoad;
            r_ld_ptr       <= '0;
            r_last_loser   <= 1'b0;
            r_conflict_cnt <= 8'h00;
            r_fetch_valid  <= 1'b0;
            r_fetch_data   <= '0;
            r_cpu_hold     <= 1'b1;
        end else begin
            r_fetch_valid <= w_fetch_gnt;
            if (w_fetch_gnt) begin
                r_fetch_data <= r_mem[fetch_addr];
            end
            // Only a fetch that actually collided and lost earns priority.
            r_last_loser <= w_in_run && w_both && w_st_gnt;
            if (w_in_run && w_both) begin
                r_conflict_cnt <= sat_inc8(r_conflict_cnt);
            end

            case (r_state)
                StLoad: begin
                    if (w_ld_gnt) begin
                        if (w_ld_last) begin
                            r_ld_ptr   <= '0;
                            r_state    <= StRun;
                            r_cpu_hold <= 1'b0;
                        end else begin
                            r_ld_ptr <= r_ld_ptr + AW'(1);
                        end
                    end
                end
                StRun: begin
                    if (reload) begin
                        // An in-flight fetch must deliver before the CPU is held.
                        if (w_fetch_gnt) begin
                            r_state <= StDrain;
                        end else begin
                            r_state    <= StLoad;
                            r_ld_ptr   <= '0;
                            r_cpu_hold <= 1'b1;
                        end
                    end
                end
                StDrain: begin
                    r_state    <= StLoad;
                    r_ld_ptr   <= '0;
                    r_cpu_hold <= 1'b1;
                end
                default: begin
                    r_state    <= StLoad;
                    r_ld_ptr   <= '0;
                    r_cpu_hold <= 1'b1;
                end
            endcase
        end
    end

    assign ld_gnt       = w_ld_gnt;
    assign load_done    = w_ld_last;
    assign fetch_gnt    = w_fetch_gnt;
    assign st_gnt       = w_st_gnt;
    assign fetch_valid  = r_fetch_valid;
    assign fetch_data   = r_fetch_data;
    assign cpu_hold     = r_cpu_hold;
    assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_pm_arbiter.sv
// Self-checking bench for pm_arbiter: directed table, corner sequences and
// randomized traffic against a behavioural model.
module tb_pm_arbiter;

    localparam int DEPTH = 16;

    logic       clk_arb = 1'b0;
    logic       rst_arb;
    logic       ld_req;
    logic [7:0] ld_data;
    logic       ld_gnt;
    logic       fetch_req;
    logic [3:0] fetch_addr;
    logic       fetch_gnt;
    logic       fetch_valid;
    logic [7:0] fetch_data;
    logic       st_req;
    logic [3:0] st_addr;
    logic [7:0] st_data;
    logic       st_gnt;
    logic       reload;
    logic       cpu_hold;
    logic       load_done;
    logic [7:0] conflict_cnt;

    pm_arbiter #(.DEPTH(DEPTH)) dut (
        .clk_arb      (clk_arb),
        .rst_arb      (rst_arb),
        .ld_req       (ld_req),
        .ld_data      (ld_data),
        .ld_gnt       (ld_gnt),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_gnt    (fetch_gnt),
        .fetch_valid  (fetch_valid),
        .fetch_data   (fetch_data),
        .st_req       (st_req),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .st_gnt       (st_gnt),
        .reload       (reload),
        .cpu_hold     (cpu_hold),
        .load_done    (load_done),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk_arb = ~clk_arb;

    typedef struct packed {
        logic       ld_gnt;
        logic       fg;
        logic       sg;
        logic       fv;
        logic       done;
        logic       hold;
        logic [7:0] fd;
        logic [7:0] cnt;
    } obs_t;

    typedef struct {
        logic       ld;
        logic       fr;
        logic [3:0] fa;
        logic       sr;
        logic [3:0] sa;
        logic [7:0] sd;
        logic       e_fg;
        logic       e_sg;
        logic       e_fv;
        logic [7:0] e_fd;
        logic [7:0] e_cnt;
    } vec_t;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: operating mode flags, loader position, memory image.
    bit         m_loading;
    bit         m_draining;
    int         m_ptr;
    logic [7:0] m_mem [DEPTH];
    bit         m_known [DEPTH];
    int         m_cnt;
    bit         m_fetch_lost;
    bit         m_fv;
    logic [7:0] m_fd;
    bit         m_fd_known;

    logic [7:0] words [DEPTH];
    vec_t       vecs [13];
    obs_t       o;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_loading    = 1'b1;
        m_draining   = 1'b0;
        m_ptr        = 0;
        m_cnt        = 0;
        m_fetch_lost = 1'b0;
        m_fv         = 1'b0;
        m_fd         = 8'h00;
        m_fd_known   = 1'b1;
    endtask

    task automatic do_reset();
        rst_arb    = 1'b1;
        ld_req     = 1'b0;
        ld_data    = 8'h00;
        fetch_req  = 1'b0;
        fetch_addr = 4'h0;
        st_req     = 1'b0;
        st_addr    = 4'h0;
        st_data    = 8'h00;
        reload     = 1'b0;
        repeat (2) @(posedge clk_arb);
        #1;
        rst_arb = 1'b0;
        model_reset();
    endtask

    // One clock cycle: drive, sample, compare against model, advance model.
    task automatic step(input logic lr, input logic [7:0] ldd, input logic fr,
                        input logic [3:0] fa, input logic sr, input logic [3:0] sa,
                        input logic [7:0] sd, input logic rl, output obs_t ob);
        bit run, both, e_ld, e_done, e_fg, e_sg;
        ld_req     = lr;
        ld_data    = ldd;
        fetch_req  = fr;
        fetch_addr = fa;
        st_req     = sr;
        st_addr    = sa;
        st_data    = sd;
        reload     = rl;
        #1;
        ob.ld_gnt = ld_gnt;
        ob.fg     = fetch_gnt;
        ob.sg     = st_gnt;
        ob.fv     = fetch_valid;
        ob.done   = load_done;
        ob.hold   = cpu_hold;
        ob.fd     = fetch_data;
        ob.cnt    = conflict_cnt;

        run    = !m_loading && !m_draining;
        both   = fr && sr;
        e_ld   = m_loading && lr;
        e_done = e_ld && (m_ptr == DEPTH - 1);
        e_fg   = run && fr && (!sr || m_fetch_lost);
        e_sg   = run && sr && !e_fg;

        chk("ld_gnt", 8'(ob.ld_gnt), 8'(e_ld));
        chk("load_done", 8'(ob.done), 8'(e_done));
        chk("fetch_gnt", 8'(ob.fg), 8'(e_fg));
        chk("st_gnt", 8'(ob.sg), 8'(e_sg));
        chk("cpu_hold", 8'(ob.hold), 8'(m_loading));
        chk("fetch_valid", 8'(ob.fv), 8'(m_fv));
        chk("conflict_cnt", ob.cnt, 8'(m_cnt));
        if (m_fd_known) chk("fetch_data", ob.fd, m_fd);

        m_fv = e_fg;
        if (e_fg) begin
            m_fd       = m_mem[fa];
            m_fd_known = m_known[fa];
        end
        if (e_ld) begin
            m_mem[m_ptr]   = ldd;
            m_known[m_ptr] = 1'b1;
            m_ptr          = (m_ptr + 1) % DEPTH;
            if (e_done) m_loading = 1'b0;
        end
        if (e_sg) begin
            m_mem[sa]   = sd;
            m_known[sa] = 1'b1;
        end
        m_fetch_lost = run && both && !e_fg;
        if (run && both && m_cnt < 255) m_cnt++;
        if (m_draining) begin
            m_draining = 1'b0;
            m_loading  = 1'b1;
            m_ptr      = 0;
        end else if (run && rl) begin
            if (e_fg) begin
                m_draining = 1'b1;
            end else begin
                m_loading = 1'b1;
                m_ptr     = 0;
            end
        end
        @(posedge clk_arb);
        #1;
    endtask

    task automatic idle(output obs_t ob);
        step(1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 4'h0, 8'h00, 1'b0, ob);
    endtask

    initial begin
        int n_done;
        int done_pos;

        for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;
        words[0] = 8'h50;
        for (int i = 1; i < DEPTH; i++) words[i] = 8'((i - 1) * 8'h11);

        // ld fr fa sr sa sd | fg sg fv fd cnt
        vecs[0]  = '{1'b0, 1'b1, 4'd2, 1'b0, 4'd0,  8'h00, 1'b1, 1'b0, 1'b0, 8'hEE, 8'd0};
        vecs[1]  = '{1'b1, 1'b0, 4'd0, 1'b0, 4'd0,  8'h00, 1'b0, 1'b0, 1'b1, 8'h11, 8'd0};
        vecs[2]  = '{1'b0, 1'b1, 4'd3, 1'b1, 4'd9,  8'h3C, 1'b0, 1'b1, 1'b0, 8'h11, 8'd0};
        vecs[3]  = '{1'b0, 1'b1, 4'd3, 1'b1, 4'd9,  8'h3D, 1'b1, 1'b0, 1'b0, 8'h11, 8'd1};
        vecs[4]  = '{1'b0, 1'b1, 4'd4, 1'b1, 4'd10, 8'h4D, 1'b0, 1'b1, 1'b1, 8'h22, 8'd2};
        vecs[5]  = '{1'b0, 1'b1, 4'd9, 1'b1, 4'd10, 8'h4E, 1'b1, 1'b0, 1'b0, 8'h22, 8'd3};
        vecs[6]  = '{1'b1, 1'b0, 4'd0, 1'b0, 4'd0,  8'h00, 1'b0, 1'b0, 1'b1, 8'h3C, 8'd4};
        vecs[7]  = '{1'b0, 1'b0, 4'd0, 1'b1, 4'd5,  8'hA7, 1'b0, 1'b1, 1'b0, 8'h3C, 8'd4};
        vecs[8]  = '{1'b0, 1'b1, 4'd5, 1'b0, 4'd0,  8'h00, 1'b1, 1'b0, 1'b0, 8'h3C, 8'd4};
        vecs[9]  = '{1'b0, 1'b0, 4'd0, 1'b0, 4'd0,  8'h00, 1'b0, 1'b0, 1'b1, 8'hA7, 8'd4};
        vecs[10] = '{1'b0, 1'b1, 4'd1, 1'b1, 4'd0,  8'h5A, 1'b0, 1'b1, 1'b0, 8'hA7, 8'd4};
        vecs[11] = '{1'b0, 1'b1, 4'd0, 1'b0, 4'd0,  8'h00, 1'b1, 1'b0, 1'b0, 8'hA7, 8'd5};
        vecs[12] = '{1'b0, 1'b0, 4'd0, 1'b0, 4'd0,  8'h00, 1'b0, 1'b0, 1'b1, 8'h5A, 8'd5};

        do_reset();

        // Reset state, observed with all inputs idle.
        idle(o);
        chk("rst cpu_hold", 8'(o.hold), 8'd1);
        chk("rst fetch_valid", 8'(o.fv), 8'd0);
        chk("rst fetch_data", o.fd, 8'h00);
        chk("rst conflict_cnt", o.cnt, 8'd0);
        chk("rst load_done", 8'(o.done), 8'd0);

        // Full program load.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, words[i], 1'b0, 4'h0, 1'b0, 4'h0, 8'h00, 1'b0, o);
            chk("load ld_gnt", 8'(o.ld_gnt), 8'd1);
            chk("load done pulse", 8'(o.done), 8'(i == DEPTH - 1));
            chk("load hold", 8'(o.hold), 8'd1);
        end

        // Read back every word; hold must already be released.
        for (int a = 0; a < DEPTH; a++) begin
            step(1'b0, 8'h00, 1'b1, 4'(a), 1'b0, 4'h0, 8'h00, 1'b0, o);
            chk("run hold", 8'(o.hold), 8'd0);
            idle(o);
            chk("readback valid", 8'(o.fv), 8'd1);
            chk($sformatf("readback mem[%0d]", a), o.fd, words[a]);
        end

        // Directed arbitration table.
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].ld, 8'h99, vecs[i].fr, vecs[i].fa, vecs[i].sr, vecs[i].sa,
                 vecs[i].sd, 1'b0, o);
            chk($sformatf("vec%0d fetch_gnt", i), 8'(o.fg), 8'(vecs[i].e_fg));
            chk($sformatf("vec%0d st_gnt", i), 8'(o.sg), 8'(vecs[i].e_sg));
            chk($sformatf("vec%0d fetch_valid", i), 8'(o.fv), 8'(vecs[i].e_fv));
            chk($sformatf("vec%0d fetch_data", i), o.fd, vecs[i].e_fd);
            chk($sformatf("vec%0d conflict_cnt", i), o.cnt, vecs[i].e_cnt);
            chk($sformatf("vec%0d ld_gnt", i), 8'(o.ld_gnt), 8'd0);
        end

        // Reload in the same cycle as a fetch grant: drain, then load.
        step(1'b0, 8'h00, 1'b1, 4'd2, 1'b0, 4'h0, 8'h00, 1'b1, o);
        chk("reload fetch_gnt", 8'(o.fg), 8'd1);
        step(1'b1, 8'h77, 1'b1, 4'd3, 1'b1, 4'd3, 8'h66, 1'b1, o);
        chk("drain fetch_gnt", 8'(o.fg), 8'd0);
        chk("drain st_gnt", 8'(o.sg), 8'd0);
        chk("drain ld_gnt", 8'(o.ld_gnt), 8'd0);
        chk("drain hold", 8'(o.hold), 8'd0);
        chk("drain fetch_valid", 8'(o.fv), 8'd1);
        chk("drain fetch_data", o.fd, 8'h11);
        n_done = 0;
        done_pos = -1;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 8'($urandom), 1'b0, 4'h0, 1'b0, 4'h0, 8'h00, 1'b0, o);
            if (i == 0) chk("reload hold", 8'(o.hold), 8'd1);
            if (o.done) begin
                n_done++;
                done_pos = i;
            end
        end
        chk("reload done count", 8'(n_done), 8'd1);
        chk("reload done pos", 8'(done_pos), 8'(DEPTH - 1));

        // Reload with no fetch granted goes straight to load.
        step(1'b0, 8'h00, 1'b0, 4'h0, 1'b0, 4'h0, 8'h00, 1'b1, o);
        idle(o);
        chk("direct reload hold", 8'(o.hold), 8'd1);

        // Reset partway through a load restarts at address 0.
        for (int i = 0; i < 7; i++) step(1'b1, 8'($urandom), 1'b0, 4'h0, 1'b0, 4'h0, 8'h00, 1'b0, o);
        do_reset();
        n_done = 0;
        done_pos = -1;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, words[i], 1'b0, 4'h0, 1'b0, 4'h0, 8'h00, 1'b0, o);
            if (o.done) begin
                n_done++;
                done_pos = i;
            end
        end
        chk("midload done count", 8'(n_done), 8'd1);
        chk("midload done pos", 8'(done_pos), 8'(DEPTH - 1));

        // Collision counter saturation.
        for (int i = 0; i < 300; i++) begin
            step(1'b0, 8'h00, 1'b1, 4'(i), 1'b1, 4'(i + 3), 8'(i), 1'b0, o);
        end
        idle(o);
        chk("conflict saturate", o.cnt, 8'd255);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 1) == 1,
                 4'($urandom), $urandom_range(0, 1) == 1, 4'($urandom), 8'($urandom),
                 $urandom_range(0, 19) == 0, o);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
